axi_lite_sram_bridge: RTL and testbench

AXI4-Lite slave that acts as the initiator for the 1024x32 single-port test SRAM. It serializes read and write transactions onto the SRAM's addr/din/dout/we port, which has one-cycle registered read latency and an active-low write enable (we=0 writes, we=1 reads). It sits between the interconnect's slave port and the SRAM in the testbench memory subsystem.

---
 rtl/axi_lite_sram_bridge_if.sv | 33 +++
 rtl/axi_lite_sram_bridge.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_sram_bridge.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_bridge_if.sv
// AXI4-Lite channel bundle between an interconnect master and the SRAM bridge.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi_lite_sram_bridge_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_sram_bridge.sv
// AXI4-Lite slave serializing reads/writes onto a 1024x32 single-port SRAM (active-low we).
// Define SRAM_BRIDGE_RMW_EN to merge partial-strobe writes via read-modify-write; otherwise they get SLVERR.
module axi_lite_sram_bridge #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_lite_sram_bridge_if.slave    axi,
  output logic [9:0]               sram_addr,
  output logic [31:0]              sram_din,
  output logic                     sram_we,
  input  logic [31:0]              sram_dout
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_SRAM, RD_CAP, RD_RESP,
`ifdef SRAM_BRIDGE_RMW_EN
    RMW_RD, RMW_MRG,
`endif
    WR_SRAM, WR_RESP
  } state_t;

  state_t      state_reg;
  logic        last_wr_reg;
  logic [9:0]  sram_addr_reg;
  logic [31:0] sram_din_reg;
  logic        sram_we_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;
  logic        rvalid_reg;
  logic [1:0]  bresp_reg;
  logic        bvalid_reg;

  logic        idle_ok;
  logic        wr_req;
  logic        grant_rd;
  logic        grant_wr;
  logic [9:0]  rd_idx;
  logic [9:0]  wr_idx;
  logic        unused_addr_bits;

  assign rd_idx           = axi.araddr[ADDR_WIDTH-1:2];
  assign wr_idx           = axi.awaddr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{axi.araddr[1:0], axi.awaddr[1:0]};

  // Fair arbitration: when both request types are pending, serve the one not served last.
  assign idle_ok  = (state_reg == IDLE) && !rst;
  assign wr_req   = axi.awvalid && axi.wvalid;
  assign grant_rd = idle_ok && axi.arvalid && (!wr_req || last_wr_reg);
  assign grant_wr = idle_ok && wr_req && (!axi.arvalid || !last_wr_reg);

  assign axi.arready = grant_rd;
  assign axi.awready = grant_wr;
  assign axi.wready  = grant_wr;
  assign axi.rdata   = rdata_reg;
  assign axi.rresp   = rresp_reg;
  assign axi.rvalid  = rvalid_reg;
  assign axi.bresp   = bresp_reg;
  assign axi.bvalid  = bvalid_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_din    = sram_din_reg;
  assign sram_we     = sram_we_reg;

`ifdef SRAM_BRIDGE_RMW_EN
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] merged;

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = wstrb_reg[gi] ? wdata_reg[8*gi +: 8] : sram_dout[8*gi +: 8];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_wr_reg   <= 1'b1;
      sram_addr_reg <= '0;
      sram_din_reg  <= '0;
      sram_we_reg   <= 1'b1;
      rdata_reg     <= '0;
      rresp_reg     <= RESP_OKAY;
      rvalid_reg    <= 1'b0;
      bresp_reg     <= RESP_OKAY;
      bvalid_reg    <= 1'b0;
`ifdef SRAM_BRIDGE_RMW_EN
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_rd) begin
            last_wr_reg   <= 1'b0;
            sram_addr_reg <= rd_idx;
            sram_we_reg   <= 1'b1;
            state_reg     <= RD_SRAM;
          end else if (grant_wr) begin
            last_wr_reg <= 1'b1;
            if (axi.wstrb == 4'hF) begin
              sram_addr_reg <= wr_idx;
              sram_din_reg  <= axi.wdata;
              sram_we_reg   <= 1'b0;
              state_reg     <= WR_SRAM;
            end else if (axi.wstrb == 4'h0) begin
              bresp_reg  <= RESP_OKAY;
              bvalid_reg <= 1'b1;
              state_reg  <= WR_RESP;
            end else begin
`ifdef SRAM_BRIDGE_RMW_EN
              sram_addr_reg <= wr_idx;
              sram_we_reg   <= 1'b1;
              wdata_reg     <= axi.wdata;
              wstrb_reg     <= axi.wstrb;
              state_reg     <= RMW_RD;
`else
              bresp_reg  <= RESP_SLVERR;
              bvalid_reg <= 1'b1;
              state_reg  <= WR_RESP;
`endif
            end
          end
        end
        // SRAM samples the address here; its data is valid one cycle later.
        RD_SRAM: state_reg <= RD_CAP;
        RD_CAP: begin
          rdata_reg  <= sram_dout;
          rresp_reg  <= RESP_OKAY;
          rvalid_reg <= 1'b1;
          state_reg  <= RD_RESP;
        end
        RD_RESP: begin
          if (axi.rready) begin
            rvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
`ifdef SRAM_BRIDGE_RMW_EN
        RMW_RD: state_reg <= RMW_MRG;
        RMW_MRG: begin
          sram_din_reg <= merged;
          sram_we_reg  <= 1'b0;
          state_reg    <= WR_SRAM;
        end
`endif
        WR_SRAM: begin
          sram_we_reg <= 1'b1;
          bresp_reg   <= RESP_OKAY;
          bvalid_reg  <= 1'b1;
          state_reg   <= WR_RESP;
        end
        WR_RESP: begin
          if (axi.bready) begin
            bvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_sram_bridge.sv
// Randomized bench for axi_lite_sram_bridge: a behavioural SRAM device plus a word-array
// reference model of memory contents, responses, latencies and arbitration order.
module tb_axi_lite_sram_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  logic        sram_we;

  int vectors = 0;
  int miscompares = 0;
  int we_low_cycles = 0;

  logic [31:0] sram_mem [1024];
  logic [31:0] ref_mem  [1024];
  bit          ref_last_wr;

  always #5 clk = ~clk;

  axi_lite_sram_bridge_if #(.ADDR_WIDTH(12)) bus ();

  axi_lite_sram_bridge #(.ADDR_WIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (bus),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_we   (sram_we),
    .sram_dout (sram_dout)
  );

  // Single-port SRAM: registered read, active-low write
  always @(posedge clk) begin
    sram_dout <= sram_mem[sram_addr];
    if (!sram_we) sram_mem[sram_addr] = sram_din;
  end

  always @(posedge clk) if (!sram_we) we_low_cycles <= we_low_cycles + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: expected memory effect, response and latency of one write
  task automatic ref_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output int we_lows);
    logic [9:0] idx;
    idx = a[11:2];
    resp = 2'b00; lat = 0; we_lows = 0;
    if (s == 4'hF) begin
      ref_mem[idx] = d; lat = 1; we_lows = 1;
    end else if (s != 4'h0) begin
`ifdef SRAM_BRIDGE_RMW_EN
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      lat = 3; we_lows = 1;
`else
      resp = 2'b10;
`endif
    end
  endtask

  // Driver tasks: entered and left at a falling edge
  task automatic ar_hs(input logic [11:0] a, output int waits);
    bus.araddr = a; bus.arvalid = 1'b1; #1; waits = 0;
    while (!bus.arready && waits < 50) begin @(negedge clk); #1; waits++; end
    if (!bus.arready) begin
      vectors++; miscompares++;
      $display("FAIL ar_handshake_timeout: arready=0 after %0d cycles, required 1", waits);
    end
    @(posedge clk); @(negedge clk); bus.arvalid = 1'b0;
  endtask

  task automatic aw_hs(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output int waits);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1'b1; bus.wvalid = 1'b1; #1; waits = 0;
    while (!(bus.awready && bus.wready) && waits < 50) begin @(negedge clk); #1; waits++; end
    if (!(bus.awready && bus.wready)) begin
      vectors++; miscompares++;
      $display("FAIL aw_handshake_timeout: awready=%b wready=%b, required 1/1", bus.awready, bus.wready);
    end
    @(posedge clk); @(negedge clk); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic wait_r(output int lat);
    lat = 0;
    while (!bus.rvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.rvalid) begin
      vectors++; miscompares++;
      $display("FAIL rvalid_timeout: rvalid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (!bus.bvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.bvalid) begin
      vectors++; miscompares++;
      $display("FAIL bvalid_timeout: bvalid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic r_ack();
    bus.rready = 1'b1; @(posedge clk); @(negedge clk); bus.rready = 1'b0;
  endtask

  task automatic b_ack();
    bus.bready = 1'b1; @(posedge clk); @(negedge clk); bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat, output int waits);
    ar_hs(a, waits); wait_r(lat);
    d = bus.rdata; resp = bus.rresp;
    r_ack(); ref_last_wr = 1'b0;
    $display("read  addr=%h data=%h resp=%0d lat=%0d", a, d, resp, lat);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat, output int waits);
    aw_hs(a, d, s, waits); wait_b(lat);
    resp = bus.bresp;
    b_ack(); ref_last_wr = 1'b1;
    $display("write addr=%h data=%h strb=%h resp=%0d lat=%0d", a, d, s, resp, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({sram_we, bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready} !== 6'b100000) begin
        miscompares++;
        $display("FAIL reset_ctrl: we,rv,bv,arr,awr,wr=%b required 100000",
                 {sram_we, bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready});
      end
    end
    vectors++;
    if ({bus.rdata, bus.rresp, bus.bresp, sram_addr, sram_din} !== 78'd0) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h rresp=%0d bresp=%0d addr=%h din=%h required all 0",
               bus.rdata, bus.rresp, bus.bresp, sram_addr, sram_din);
    end
    @(negedge clk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0; rst = 1'b0;
    ref_last_wr = 1'b1;
    $display("reset done");
  endtask

  task automatic test_full_write_read();
    logic [1:0] resp, eresp; logic [31:0] d, expd; logic [11:0] a, ra;
    int lat, elat, ewe, w, we0;
    we0 = we_low_cycles;
    ref_write(12'h040, 32'hDEADBEEF, 4'hF, eresp, elat, ewe);
    do_write(12'h040, 32'hDEADBEEF, 4'hF, resp, lat, w);
    vectors++;
    if (resp !== 2'b00 || lat != 1) begin
      miscompares++; $display("FAIL full_write_resp: resp=%0d lat=%0d required 0/1", resp, lat);
    end
    vectors++;
    if (we_low_cycles - we0 != 1) begin
      miscompares++; $display("FAIL full_write_we_pulse: we low %0d cycles required 1", we_low_cycles - we0);
    end
    vectors++;
    if (sram_mem[10'h010] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL full_write_sram: word 0x010=%h required deadbeef", sram_mem[10'h010]);
    end
    do_read(12'h040, d, resp, lat, w);
    vectors++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00 || lat != 2) begin
      miscompares++; $display("FAIL full_read: data=%h resp=%0d lat=%0d required deadbeef/0/2", d, resp, lat);
    end
    for (int i = 0; i < 12; i++) begin
      a = 12'($urandom); d = $urandom;
      ref_write(a, d, 4'hF, eresp, elat, ewe);
      do_write(a, d, 4'hF, resp, lat, w);
      vectors++;
      if (resp !== eresp || lat != elat) begin
        miscompares++; $display("FAIL rand_full_write: resp=%0d lat=%0d required %0d/%0d", resp, lat, eresp, elat);
      end
      ra = ($urandom_range(0, 1) != 0) ? (a ^ 12'($urandom_range(0, 3))) : 12'($urandom);
      expd = ref_mem[ra[11:2]];
      do_read(ra, d, resp, lat, w);
      vectors++;
      if (d !== expd || lat != 2) begin
        miscompares++; $display("FAIL rand_read addr=%h: data=%h lat=%0d required %h/2", ra, d, lat, expd);
      end
    end
  endtask

  task automatic test_partial();
    logic [1:0] resp, eresp; logic [31:0] d, expd; logic [11:0] a; logic [3:0] s;
    int lat, elat, ewe, w, we0;
    ref_write(12'h080, 32'h11223344, 4'hF, eresp, elat, ewe);
    do_write(12'h080, 32'h11223344, 4'hF, resp, lat, w);
    we0 = we_low_cycles;
    ref_write(12'h080, 32'hAABBCCDD, 4'b0101, eresp, elat, ewe);
    do_write(12'h080, 32'hAABBCCDD, 4'b0101, resp, lat, w);
`ifdef SRAM_BRIDGE_RMW_EN
    expd = 32'h11BB33DD;
    vectors++;
    if (resp !== 2'b00 || lat != 3) begin
      miscompares++; $display("FAIL partial_resp: resp=%0d lat=%0d required 0/3", resp, lat);
    end
`else
    expd = 32'h11223344;
    vectors++;
    if (resp !== 2'b10 || lat != 0) begin
      miscompares++; $display("FAIL partial_resp: resp=%0d lat=%0d required 2/0", resp, lat);
    end
`endif
    vectors++;
    if (we_low_cycles - we0 != ewe) begin
      miscompares++; $display("FAIL partial_we_pulse: we low %0d cycles required %0d", we_low_cycles - we0, ewe);
    end
    do_read(12'h080, d, resp, lat, w);
    vectors++;
    if (d !== expd) begin
      miscompares++; $display("FAIL partial_readback: data=%h required %h", d, expd);
    end
    for (int i = 0; i < 12; i++) begin
      a = 12'($urandom); d = $urandom; s = 4'($urandom);
      we0 = we_low_cycles;
      ref_write(a, d, s, eresp, elat, ewe);
      do_write(a, d, s, resp, lat, w);
      vectors++;
      if (resp !== eresp || lat != elat || (we_low_cycles - we0) != ewe) begin
        miscompares++;
        $display("FAIL rand_strobe strb=%h: resp=%0d lat=%0d welow=%0d required %0d/%0d/%0d",
                 s, resp, lat, we_low_cycles - we0, eresp, elat, ewe);
      end
      expd = ref_mem[a[11:2]];
      do_read(a, d, resp, lat, w);
      vectors++;
      if (d !== expd) begin
        miscompares++; $display("FAIL rand_strobe_readback addr=%h: data=%h required %h", a, d, expd);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] resp, eresp; logic [31:0] d, old, rd; logic [11:0] a;
    int lat, elat, ewe, w; bit read_first;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) != 0) begin
        a = 12'($urandom);
        if ($urandom_range(0, 1) != 0) do_read(a, rd, resp, lat, w);
        else begin
          d = $urandom; ref_write(a, d, 4'hF, eresp, elat, ewe); do_write(a, d, 4'hF, resp, lat, w);
        end
      end
      a = 12'($urandom); d = $urandom;
      read_first = ref_last_wr;
      old = ref_mem[a[11:2]];
      bus.araddr = a; bus.arvalid = 1'b1;
      bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      #1;
      vectors++;
      if ({bus.arready, bus.awready, bus.wready} !== (read_first ? 3'b100 : 3'b011)) begin
        miscompares++;
        $display("FAIL arbitration: arready,awready,wready=%b required %b",
                 {bus.arready, bus.awready, bus.wready}, read_first ? 3'b100 : 3'b011);
      end
      @(posedge clk); @(negedge clk);
      if (read_first) begin
        bus.arvalid = 1'b0;
        wait_r(lat); rd = bus.rdata; r_ack(); ref_last_wr = 1'b0;
        $display("read  addr=%h data=%h (arbitrated first)", a, rd);
        ref_write(a, d, 4'hF, eresp, elat, ewe);
        do_write(a, d, 4'hF, resp, lat, w);
        vectors++;
        if (rd !== old || w != 0) begin
          miscompares++; $display("FAIL arb_read_first: data=%h waits=%0d required %h/0", rd, w, old);
        end
      end else begin
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b(lat); b_ack();
        ref_write(a, d, 4'hF, eresp, elat, ewe); ref_last_wr = 1'b1;
        $display("write addr=%h data=%h (arbitrated first)", a, d);
        do_read(a, rd, resp, lat, w);
        vectors++;
        if (rd !== d || w != 0) begin
          miscompares++; $display("FAIL arb_write_first: data=%h waits=%0d required %h/0", rd, w, d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp, eresp; logic [31:0] d, expd; logic [11:0] a;
    int lat, elat, ewe, w;
    for (int i = 0; i < 10; i++) begin
      a = 12'($urandom);
      if ((i % 2) == 0) begin
        d = $urandom; ref_write(a, d, 4'hF, eresp, elat, ewe);
        do_write(a, d, 4'hF, resp, lat, w);
        vectors++;
        if (w != 0 || lat != 1) begin
          miscompares++; $display("FAIL b2b_write: waits=%0d lat=%0d required 0/1", w, lat);
        end
      end else begin
        expd = ref_mem[a[11:2]];
        do_read(a, d, resp, lat, w);
        vectors++;
        if (w != 0 || d !== expd) begin
          miscompares++; $display("FAIL b2b_read: waits=%0d data=%h required 0/%h", w, d, expd);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp, eresp; logic [31:0] d, expd; logic [11:0] a;
    int lat, elat, ewe, w;
    a = 12'($urandom); d = $urandom;
    ref_write(a, d, 4'hF, eresp, elat, ewe); do_write(a, d, 4'hF, resp, lat, w);
    expd = ref_mem[a[11:2]];
    ar_hs(a, w); wait_r(lat);
    bus.araddr = a ^ 12'h100; bus.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({bus.rvalid, bus.rdata, bus.arready} !== {1'b1, expd, 1'b0}) begin
        miscompares++;
        $display("FAIL r_backpressure cyc %0d: rvalid=%b rdata=%h arready=%b required 1/%h/0",
                 i, bus.rvalid, bus.rdata, bus.arready, expd);
      end
      @(negedge clk);
    end
    bus.arvalid = 1'b0; r_ack(); ref_last_wr = 1'b0;
    $display("read  addr=%h data=%h (held 5 cycles)", a, expd);
    vectors++;
    if (bus.rvalid !== 1'b0) begin
      miscompares++; $display("FAIL r_release: rvalid=%b required 0", bus.rvalid);
    end
    a = 12'($urandom); d = $urandom;
    ref_write(a, d, 4'hF, eresp, elat, ewe);
    aw_hs(a, d, 4'hF, w); wait_b(lat);
    bus.awaddr = a ^ 12'h200; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
        miscompares++;
        $display("FAIL b_backpressure cyc %0d: bvalid=%b bresp=%0d awready=%b wready=%b required 1/0/0/0",
                 i, bus.bvalid, bus.bresp, bus.awready, bus.wready);
      end
      @(negedge clk);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; b_ack(); ref_last_wr = 1'b1;
    $display("write addr=%h data=%h (held 5 cycles)", a, d);
    vectors++;
    if (bus.bvalid !== 1'b0) begin
      miscompares++; $display("FAIL b_release: bvalid=%b required 0", bus.bvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, eresp; logic [31:0] d, rd; logic [11:0] a;
    int lat, elat, ewe, w;
    a = 12'($urandom); d = $urandom;
    ref_write(a, d, 4'hF, eresp, elat, ewe); do_write(a, d, 4'hF, resp, lat, w);
    ar_hs(a, w);
    @(negedge clk);
    rst = 1'b1; bus.araddr = a; bus.arvalid = 1'b1; #1;
    vectors++;
    if (bus.arready !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_ready: arready=%b required 0", bus.arready);
    end
    @(negedge clk); #1;
    vectors++;
    if ({bus.rvalid, bus.bvalid, bus.arready} !== 3'b000) begin
      miscompares++; $display("FAIL rst_mid_read: rvalid,bvalid,arready=%b required 000",
                              {bus.rvalid, bus.bvalid, bus.arready});
    end
    rst = 1'b0; #1;
    vectors++;
    if (bus.arready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_idle: arready=%b required 1", bus.arready);
    end
    bus.arvalid = 1'b0; ref_last_wr = 1'b1;
    @(negedge clk);
    $display("reset during read addr=%h", a);
    do_read(a, rd, resp, lat, w);
    vectors++;
    if (rd !== d) begin
      miscompares++; $display("FAIL rst_mid_reread: data=%h required %h", rd, d);
    end
    a = 12'($urandom); d = $urandom;
    aw_hs(a, d, 4'hF, w);
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({bus.bvalid, sram_we} !== 2'b01) begin
      miscompares++; $display("FAIL rst_mid_write: bvalid,sram_we=%b required 01", {bus.bvalid, sram_we});
    end
    rst = 1'b0; ref_last_wr = 1'b1;
    ref_write(a, d, 4'hF, eresp, elat, ewe);
    @(negedge clk);
    vectors++;
    if (bus.bvalid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_no_bresp: bvalid=%b required 0", bus.bvalid);
    end
    $display("reset during write addr=%h data=%h", a, d);
    do_read(a, rd, resp, lat, w);
    vectors++;
    if (rd !== d) begin
      miscompares++; $display("FAIL rst_mid_write_landed: data=%h required %h", rd, d);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin sram_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_full_write_read();
    test_partial();
    test_arbitration();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
